// File: rtl/request_unit.sv
// request_unit: memory-side sequencer for the single-cycle datapath.
// It issues exactly one instruction fetch per instruction and at most one
// data access. PC advance is gated until the instruction has fully completed.
// Optional statistics counters are enabled by the macro REQUEST_UNIT_STATS_EN.
module request_unit #(
   parameter int DATA_TIMEOUT = 0,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             MemRd,
   input  logic             MemWr,
   input  logic             halt,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             halted,
   output logic             timeout_err
`ifdef REQUEST_UNIT_STATS_EN
   ,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] dacc_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DATA  = 2'd1,
      HALT  = 2'd2
   } state_e;

   localparam bit             WD_EN   = (DATA_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(DATA_TIMEOUT - 1) : '0;

   state_e           state_q, state_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             terr_q, terr_d;
   logic             adv;
   logic             wd_fire;

   // Next-state, latched access type, watchdog and PC-advance decision
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      wd_d    = wd_q;
      terr_d  = terr_q;
      adv     = 1'b0;
      wd_fire = 1'b0;
      case (state_q)
         FETCH: begin
            if (ihit) begin
               if (halt) begin
                  state_d = HALT;
               end else if (MemRd || MemWr) begin
                  // a store wins when both strobes are set
                  wr_d    = MemWr;
                  rd_d    = MemRd & ~MemWr;
                  wd_d    = '0;
                  state_d = DATA;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         DATA: begin
            if (dhit) begin
               adv     = 1'b1;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = FETCH;
            end else if (WD_EN && (wd_q == WD_LAST)) begin
               // abandon the access; the instruction retires so the PC moves on
               wd_fire = 1'b1;
               terr_d  = 1'b1;
               adv     = 1'b1;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = FETCH;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= FETCH;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wd_q    <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wd_q    <= wd_d;
         terr_q  <= terr_d;
      end
   end

   // Outputs derive from state; reset forces them low in the same cycle
   always_comb begin
      imemREN     = ~RST & (state_q == FETCH);
      dmemREN     = ~RST & (state_q == DATA) & rd_q;
      dmemWEN     = ~RST & (state_q == DATA) & wr_q;
      pc_en       = ~RST & adv;
      halted      = ~RST & (state_q == HALT);
      timeout_err = ~RST & (terr_q | wd_fire);
   end

`ifdef REQUEST_UNIT_STATS_EN
   logic [CNT_W-1:0] instr_q, dacc_q, stall_q;

   // Wrapping statistics counters, frozen while halted
   always_ff @(posedge CLK) begin
      if (RST) begin
         instr_q <= '0;
         dacc_q  <= '0;
         stall_q <= '0;
      end else if (state_q != HALT) begin
         if (adv)                         instr_q <= instr_q + 1'b1;
         if ((state_q == DATA) && dhit)   dacc_q  <= dacc_q + 1'b1;
         if ((state_q == DATA) && !dhit)  stall_q <= stall_q + 1'b1;
      end
   end

   assign instr_cnt = instr_q;
   assign dacc_cnt  = dacc_q;
   assign stall_cnt = stall_q;
`endif

endmodule
